// File: rtl/i2c_target_responder.sv
// I2C target: synchronises and filters SCL/SDA, decodes START/STOP, matches
// the device address and turns written bytes into register-write strobes and
// read transfers into register-read requests. Register pointer auto-increments.
module i2c_target_responder #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1010000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
  logic [1:0] pin_s1, pin_s2;
  logic [1:0] pin_f, pin_d;
  logic [3:0] flt_cnt [2];

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [6:0] tx;
  logic [7:0] ptr;
  logic       rw;
  logic       rd_pend;
  logic       ack_seen;

  logic       scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] shift_next;

  // Two-flop synchroniser for both pins.
  // NOTE: synchroniser and filter reset to 1 (idle bus) so leaving reset never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pin_s1 <= 2'b11;
      pin_s2 <= 2'b11;
    end else begin
      pin_s1 <= {i_scl, i_sda};
      pin_s2 <= pin_s1;
    end
  end

  // Glitch filter: accept a new level only after FILTER_LEN equal samples; keep previous level for edges.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pin_f <= 2'b11;
      pin_d <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      pin_d <= pin_f;
      for (int i = 0; i < 2; i++) begin
        if (pin_s2[i] == pin_f[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_LAST) begin
          pin_f[i]   <= pin_s2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign scl_rise   = pin_f[1] & ~pin_d[1];
  assign scl_fall   = ~pin_f[1] & pin_d[1];
  assign start_cond = pin_f[1] & pin_d[1] & pin_d[0] & ~pin_f[0];
  assign stop_cond  = pin_f[1] & pin_d[1] & ~pin_d[0] & pin_f[0];
  assign shift_next = {shift, pin_f[0]};

  // Protocol FSM: bit shifting, ACK driving, pointer and register-port strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      rd_pend    <= 1'b0;
      ack_seen   <= 1'b0;
      o_sda_oe   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_rd_req   <= 1'b0;
      o_rd_addr  <= '0;
      o_busy     <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so a single set yields exactly a one-clock pulse.
      o_wr_valid <= 1'b0;
      o_rd_req   <= 1'b0;
      rd_pend    <= 1'b0;
      if (start_cond) begin
        state    <= S_ADDR;
        bit_cnt  <= '0;
        o_sda_oe <= 1'b0;
        ack_seen <= 1'b0;
      end else if (stop_cond) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shift   <= shift_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift_next[7:1] == SLAVE_ADDR) begin
                state <= S_ADDR_ACK;
                rw    <= shift_next[0];
              end else begin
                state  <= S_WAIT_STOP;
                o_busy <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            if (!o_sda_oe) begin
              o_sda_oe <= 1'b1;
              o_busy   <= 1'b1;
            end else begin
              o_sda_oe <= 1'b0;
              if (rw) begin
                state     <= S_RDATA;
                o_rd_req  <= 1'b1;
                o_rd_addr <= ptr;
                rd_pend   <= 1'b1;
              end else begin
                state <= S_REG;
              end
            end
          end
          S_REG: if (scl_rise) begin
            shift   <= shift_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= shift_next;
              state <= S_REG_ACK;
            end
          end
          S_REG_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!o_sda_oe) begin
              o_sda_oe <= 1'b1;
            end else begin
              o_sda_oe <= 1'b0;
              state    <= S_WDATA;
            end
          end
          S_WDATA: if (scl_rise) begin
            shift   <= shift_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              o_wr_valid <= 1'b1;
              o_wr_addr  <= ptr;
              o_wr_data  <= shift_next;
              ptr        <= ptr + 8'd1;
              state      <= S_WDATA_ACK;
            end
          end
          S_RDATA: begin
            if (rd_pend) begin
              tx       <= i_rd_data[6:0];
              o_sda_oe <= ~i_rd_data[7];
            end else if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_sda_oe <= 1'b0;
                ptr      <= ptr + 8'd1;
                ack_seen <= 1'b0;
                state    <= S_RDATA_ACK;
              end else begin
                o_sda_oe <= ~tx[6];
                tx       <= {tx[5:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (pin_f[0]) state <= S_WAIT_STOP;
              else          ack_seen <= 1'b1;
            end else if (scl_fall && ack_seen) begin
              ack_seen  <= 1'b0;
              state     <= S_RDATA;
              o_rd_req  <= 1'b1;
              o_rd_addr <= ptr;
              rd_pend   <= 1'b1;
            end
          end
          default: o_sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
